// File: rtl/bpm_avg_if.sv
// Handshake bundle between the interval detector, the BPM averager and the
// display/host copy logic. The averager is the slave side.
interface bpm_avg_if #(
    parameter int WIDTH = 8,
    parameter int OUT_W = 8
);
    logic [WIDTH-1:0] interval_count;
    logic             interval_valid;
    logic             interval_ready;
    logic [OUT_W-1:0] bpm_value;
    logic             bpm_valid;
    logic             bpm_copied;
    logic             bpm_reject;
    logic             overrun;

    modport master (
        output interval_count, interval_valid, bpm_copied,
        input  interval_ready, bpm_value, bpm_valid, bpm_reject, overrun
    );

    modport slave (
        input  interval_count, interval_valid, bpm_copied,
        output interval_ready, bpm_value, bpm_valid, bpm_reject, overrun
    );
endinterface

// File: rtl/bpm_avg_calculator.sv
// Beat-rate averager: range-checks peak-to-peak interval counts, keeps a
// ring of the last AVG_DEPTH good intervals and converts their mean into a
// rounded BPM value with a 16-cycle restoring divider.
module bpm_avg_calculator #(
    parameter int WIDTH     = 8,
    parameter int FS        = 25,
    parameter int AVG_DEPTH = 4,
    parameter int BPM_MIN   = 30,
    parameter int BPM_MAX   = 220,
    parameter int OUT_W     = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      en,
    input  logic      clear_hist,
    bpm_avg_if.slave  bus
);
    localparam int K      = 60 * FS;                         // ticks per minute
    localparam int IMAX   = K / BPM_MIN;                     // longest legal interval
    localparam int IMIN   = (K + BPM_MAX - 1) / BPM_MAX;     // shortest legal interval
    localparam int LOG_D  = $clog2(AVG_DEPTH);
    localparam int PTR_W  = (LOG_D > 0) ? LOG_D : 1;
    localparam int SUM_W  = WIDTH + LOG_D;
    localparam int FILL_W = $clog2(AVG_DEPTH + 1);
    localparam int N_MAX  = K * AVG_DEPTH + ((2 ** SUM_W - 1) >> 1);
    localparam int N_W    = ($clog2(N_MAX + 1) > 16) ? $clog2(N_MAX + 1) : 16;
    localparam int Q_W    = 16;
    localparam int SAT    = (1 << OUT_W) - 1;

    typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;

    state_t            state;
    logic [WIDTH-1:0]  hist [AVG_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [SUM_W-1:0]  sum;
    logic [FILL_W-1:0] fill;
    logic [WIDTH-1:0]  int_q;
    logic [SUM_W-1:0]  div_d;
    logic [SUM_W-1:0]  rem;
    logic [Q_W-1:0]    q_sh;
    logic [3:0]        bit_cnt;
    logic [OUT_W-1:0]  bpm_value_q;
    logic              bpm_valid_q;
    logic              reject_q;
    logic              overrun_q;

    logic              ready;
    logic              in_range;
    logic [WIDTH-1:0]  evicted;
    logic [SUM_W-1:0]  new_sum;
    logic [FILL_W-1:0] new_fill;
    logic [N_W-1:0]    num;
    logic [SUM_W:0]    trial;
    logic              take;
    logic [SUM_W-1:0]  diff;

    // Ready is forced low while reset is asserted so every output reads 0.
    assign ready    = rst_n && en && (state == IDLE) && !bpm_valid_q;
    assign in_range = (int'(bus.interval_count) >= IMIN) &&
                      (int'(bus.interval_count) <= IMAX);

    // Running-sum update: the slot about to be overwritten only counts once
    // the ring has wrapped.
    assign evicted  = (fill == FILL_W'(AVG_DEPTH)) ? hist[wr_ptr] : '0;
    assign new_sum  = sum + SUM_W'(int_q) - SUM_W'(evicted);
    assign new_fill = (fill == FILL_W'(AVG_DEPTH)) ? fill : fill + FILL_W'(1);
    // Adding half the divisor turns the truncating divide into round-half-up.
    assign num      = N_W'(K) * N_W'(new_fill) + N_W'(new_sum >> 1);

    // One restoring-divide step: shift in the next dividend bit, subtract
    // the divisor when it fits. The true difference is below div_d, so the
    // low SUM_W bits of the subtraction are exact.
    assign trial = {rem, q_sh[Q_W-1]};
    assign take  = trial >= {1'b0, div_d};
    assign diff  = trial[SUM_W-1:0] - div_d;

    assign bus.interval_ready = ready;
    assign bus.bpm_value      = bpm_value_q;
    assign bus.bpm_valid      = bpm_valid_q;
    assign bus.bpm_reject     = reject_q;
    assign bus.overrun        = overrun_q;

    // Control FSM, history ring, divider datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            // NOTE: the history is a handful of registers, not a RAM, so it is
            // reset along with everything else and never holds stale samples.
            for (int i = 0; i < AVG_DEPTH; i++) hist[i] <= '0;
            wr_ptr      <= '0;
            sum         <= '0;
            fill        <= '0;
            int_q       <= '0;
            div_d       <= '0;
            rem         <= '0;
            q_sh        <= '0;
            bit_cnt     <= '0;
            bpm_value_q <= '0;
            bpm_valid_q <= 1'b0;
            reject_q    <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every branch below read the
            // pre-edge values, so later defaults cannot leak into earlier logic.
            reject_q  <= 1'b0;
            overrun_q <= 1'b0;

            if (bpm_valid_q && bus.bpm_copied) bpm_valid_q <= 1'b0;
            if (en && bus.interval_valid && !ready) overrun_q <= 1'b1;

            if (clear_hist) begin
                // Flush wins over everything, including an accept on this edge.
                for (int i = 0; i < AVG_DEPTH; i++) hist[i] <= '0;
                wr_ptr <= '0;
                sum    <= '0;
                fill   <= '0;
                state  <= IDLE;
            end else if (!en) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.interval_valid && ready) begin
                            if (in_range) begin
                                int_q <= bus.interval_count;
                                state <= LOAD;
                            end else begin
                                reject_q <= 1'b1;
                            end
                        end
                    end
                    LOAD: begin
                        hist[wr_ptr] <= int_q;
                        wr_ptr  <= (wr_ptr == PTR_W'(AVG_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
                        sum     <= new_sum;
                        fill    <= new_fill;
                        div_d   <= new_sum;
                        rem     <= SUM_W'(num >> Q_W);
                        q_sh    <= num[Q_W-1:0];
                        bit_cnt <= '0;
                        state   <= DIV;
                    end
                    DIV: begin
                        rem     <= take ? diff : trial[SUM_W-1:0];
                        q_sh    <= {q_sh[Q_W-2:0], take};
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd15) state <= DONE;
                    end
                    DONE: begin
                        bpm_value_q <= (int'(q_sh) > SAT) ? '1 : q_sh[OUT_W-1:0];
                        bpm_valid_q <= 1'b1;
                        state       <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bpm_avg_calculator.sv
// Self-checking bench for bpm_avg_calculator: a constant vector table,
// randomized intervals against a queue-based averaging model, and
// hand-written abort/overrun/reset sequences.
module tb_bpm_avg_calculator;
    localparam int K    = 1500;   // 60 * 25 Hz
    localparam int IMIN = 7;
    localparam int IMAX = 50;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b1;
    logic clear_hist = 1'b0;

    bpm_avg_if #(.WIDTH(8), .OUT_W(8)) bus ();

    bpm_avg_calculator #(
        .WIDTH(8), .FS(25), .AVG_DEPTH(4), .BPM_MIN(30), .BPM_MAX(220), .OUT_W(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .clear_hist (clear_hist),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int hist_q[$];

    typedef struct {
        int interval;
        bit rej;
        int bpm;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: mean of the last DEPTH good intervals, BPM rounded
    // to nearest with ties up, computed as floor((2*K*n + s) / (2*s)).
    function automatic void model_push(input int v);
        if (hist_q.size() == DEPTH) void'(hist_q.pop_front());
        hist_q.push_back(v);
    endfunction

    function automatic int model_bpm();
        int s = 0;
        int r;
        foreach (hist_q[i]) s += hist_q[i];
        r = (2 * K * hist_q.size() + s) / (2 * s);
        return (r > 255) ? 255 : r;
    endfunction

    // Offer one interval (called just after a falling edge), follow it to a
    // result if accepted and copy that result.
    task automatic offer(input int v, output bit rej, output bit ovr, output int bpm,
                         output int lat, output bit busy_ready);
        bus.interval_count = 8'(v);
        bus.interval_valid = 1'b1;
        @(negedge clk);
        bus.interval_valid = 1'b0;
        rej = bus.bpm_reject;
        ovr = bus.overrun;
        bpm = -1;
        lat = 0;
        busy_ready = 1'b0;
        if (!rej) begin
            while (!bus.bpm_valid && lat < 40) begin
                if (bus.interval_ready) busy_ready = 1'b1;
                @(negedge clk);
                lat++;
            end
            if (bus.bpm_valid) bpm = int'(bus.bpm_value);
            bus.bpm_copied = 1'b1;
            @(negedge clk);
            bus.bpm_copied = 1'b0;
        end
    endtask

    task automatic expect_result(input string tag, input int v, input bit exp_rej, input int exp_bpm);
        bit rej, ovr, busy;
        int bpm, lat;
        check({tag, " ready_before"}, bus.interval_ready, 1);
        offer(v, rej, ovr, bpm, lat, busy);
        check({tag, " reject"}, rej, exp_rej);
        check({tag, " overrun"}, ovr, 0);
        if (!exp_rej) begin
            check({tag, " latency"}, lat, 18);
            check({tag, " bpm"}, bpm, exp_bpm);
            check({tag, " ready_busy"}, busy, 0);
            check({tag, " valid_after_copy"}, bus.bpm_valid, 0);
            check({tag, " ready_after_copy"}, bus.interval_ready, 1);
        end else begin
            check({tag, " no_valid"}, bus.bpm_valid, 0);
        end
    endtask

    task automatic no_result(input string tag, input int n);
        bit seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (bus.bpm_valid) seen = 1'b1;
        end
        check(tag, seen, 0);
    endtask

    // Start a computation and stop after a few divide cycles.
    task automatic start_and_wait(input int v, input int n);
        bus.interval_count = 8'(v);
        bus.interval_valid = 1'b1;
        @(negedge clk);
        bus.interval_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    vec_t tbl[11];

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit exp_rej;
        int v;
        bus.interval_count = '0;
        bus.interval_valid = 1'b0;
        bus.bpm_copied     = 1'b0;

        tbl[0]  = '{25, 1'b0, 60};
        tbl[1]  = '{25, 1'b0, 60};
        tbl[2]  = '{20, 1'b0, 64};
        tbl[3]  = '{20, 1'b0, 67};
        tbl[4]  = '{5,  1'b1, 0};
        tbl[5]  = '{0,  1'b1, 0};
        tbl[6]  = '{51, 1'b1, 0};
        tbl[7]  = '{30, 1'b0, 63};
        tbl[8]  = '{7,  1'b0, 78};
        tbl[9]  = '{50, 1'b0, 56};
        tbl[10] = '{6,  1'b1, 0};

        // Reset state, with en already high.
        #2;
        check("reset ready", bus.interval_ready, 0);
        check("reset valid", bus.bpm_valid, 0);
        check("reset value", bus.bpm_value, 0);
        check("reset reject", bus.bpm_reject, 0);
        check("reset overrun", bus.overrun, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Constant vector table from empty history.
        for (int i = 0; i < 11; i++) begin
            expect_result($sformatf("tbl%0d", i), tbl[i].interval, tbl[i].rej, tbl[i].bpm);
            if (!tbl[i].rej) model_push(tbl[i].interval);
        end

        // Overrun while a result is pending and uncopied.
        model_push(25);
        start_and_wait(25, 0);
        begin
            int lat = 0;
            while (!bus.bpm_valid && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            check("ovr latency", lat, 18);
        end
        check("ovr held bpm", bus.bpm_value, model_bpm());
        check("ovr ready_low", bus.interval_ready, 0);
        bus.interval_count = 8'd20;
        bus.interval_valid = 1'b1;
        @(negedge clk);
        bus.interval_valid = 1'b0;
        check("ovr pulse", bus.overrun, 1);
        check("ovr no_reject", bus.bpm_reject, 0);
        @(negedge clk);
        check("ovr pulse_end", bus.overrun, 0);
        check("ovr valid_held", bus.bpm_valid, 1);
        bus.bpm_copied = 1'b1;
        @(negedge clk);
        bus.bpm_copied = 1'b0;
        check("ovr ready_after_copy", bus.interval_ready, 1);
        model_push(30);
        expect_result("ovr hist_unchanged", 30, 1'b0, model_bpm());

        // Asynchronous reset in the middle of a divide.
        start_and_wait(25, 5);
        rst_n = 1'b0;
        #1;
        check("midrst ready", bus.interval_ready, 0);
        check("midrst valid", bus.bpm_valid, 0);
        check("midrst value", bus.bpm_value, 0);
        check("midrst reject", bus.bpm_reject, 0);
        check("midrst overrun", bus.overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        hist_q.delete();
        @(negedge clk);

        // clear_hist on the same edge as an accept discards the interval.
        bus.interval_count = 8'd30;
        bus.interval_valid = 1'b1;
        clear_hist = 1'b1;
        @(negedge clk);
        bus.interval_valid = 1'b0;
        clear_hist = 1'b0;
        check("clracc reject", bus.bpm_reject, 0);
        check("clracc overrun", bus.overrun, 0);
        check("clracc ready", bus.interval_ready, 1);
        no_result("clracc no_valid", 22);
        model_push(20);
        expect_result("after_clear", 20, 1'b0, 75);

        // en dropped mid-divide: no result, history update from LOAD kept.
        start_and_wait(25, 5);
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        no_result("en_abort no_valid", 22);
        check("en_abort ready", bus.interval_ready, 1);
        model_push(25);
        model_push(20);
        expect_result("en_abort hist_kept", 20, 1'b0, model_bpm());

        // With en low, offered intervals produce no pulses and are not taken.
        en = 1'b0;
        bus.interval_count = 8'd3;
        bus.interval_valid = 1'b1;
        @(negedge clk);
        check("en_low reject", bus.bpm_reject, 0);
        check("en_low overrun", bus.overrun, 0);
        bus.interval_valid = 1'b0;
        en = 1'b1;
        no_result("en_low no_valid", 20);

        // clear_hist mid-divide: abort and empty history.
        start_and_wait(30, 6);
        clear_hist = 1'b1;
        @(negedge clk);
        clear_hist = 1'b0;
        no_result("clr_abort no_valid", 22);
        hist_q.delete();
        model_push(25);
        expect_result("clr_abort fresh", 25, 1'b0, 60);

        // Randomized intervals against the averaging model.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 99) < 8) begin
                clear_hist = 1'b1;
                @(negedge clk);
                clear_hist = 1'b0;
                hist_q.delete();
            end else begin
                v = int'($urandom_range(0, 60));
                exp_rej = (v < IMIN) || (v > IMAX);
                if (!exp_rej) model_push(v);
                expect_result($sformatf("rnd%0d v=%0d", i, v), v, exp_rej,
                              exp_rej ? 0 : model_bpm());
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bpm_avg_calculator.md
Name: bpm_avg_calculator

Overview:
Next-generation beat-rate calculator. It converts peak-to-peak interval counts (ticks at FS Hz) into BPM, averaged over the last AVG_DEPTH accepted beats. Intervals outside the physiological range are rejected. Division is done by a multi-cycle restoring divider rather than a combinational one. It sits between the peak/interval detector and the display/host register copy logic, and keeps the existing bpm_valid/bpm_copied handshake.

Parameters:
WIDTH, 8, interval_count width in bits.
FS, 25, sampling rate of interval ticks in Hz.
AVG_DEPTH, 4, history depth. Power of 2, range 1..16.
BPM_MIN, 30, lowest accepted rate. Sets the longest legal interval: IMAX = floor(60*FS/BPM_MIN) = 50.
BPM_MAX, 220, highest accepted rate. Sets the shortest legal interval: IMIN = ceil(60*FS/BPM_MAX) = 7.
OUT_W, 8, bpm_value width.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
en  in  1  block enable
clear_hist  in  1  synchronous flush of interval history
interval_count  in  WIDTH  interval in FS ticks
interval_valid  in  1  interval_count is valid this cycle
interval_ready  out  1  block can accept an interval this cycle
bpm_value  out  OUT_W  averaged BPM, rounded to nearest
bpm_valid  out  1  bpm_value is new; held until copied
bpm_copied  in  1  consumer has taken bpm_value
bpm_reject  out  1  1-cycle pulse: interval out of range, discarded
overrun  out  1  1-cycle pulse: interval offered while interval_ready was low, dropped

Behaviour:
- Reset (async, rst_n low): all outputs are 0, state is IDLE, history/sum/fill are cleared, divider registers are cleared.
- interval_ready = en && state==IDLE && !bpm_valid.
- Accept: on an edge where interval_valid && interval_ready:
  - If interval_count < IMIN or > IMAX (this includes 0): pulse bpm_reject, leave history unchanged, stay in IDLE.
  - Otherwise go to LOAD.
- interval_valid && !interval_ready && en: pulse overrun; the interval is dropped. With en low, inputs are ignored and no pulses are generated.
- State machine IDLE -> LOAD -> DIV -> DONE -> IDLE.
  - LOAD (1 cycle): write the interval into the ring buffer at wr_ptr and advance wr_ptr mod AVG_DEPTH. sum = sum + new - evicted, where evicted is 0 until the buffer is full. fill increments and saturates at AVG_DEPTH. Form numerator N = 60*FS*fill + (sum>>1) and divisor D = sum.
  - DIV (16 cycles): restoring divide, one quotient bit per cycle, MSB first, 16-bit quotient.
  - DONE (1 cycle): bpm_value = quotient, saturated to 2^OUT_W-1. Set bpm_valid.
- Latency: interval sampled on edge T gives bpm_valid=1 on edge T+18. Fixed, data-independent.
- Widths:
  - sum is WIDTH+log2(AVG_DEPTH) bits and never overflows.
  - N is at least 16 bits, sized to hold 60*FS*AVG_DEPTH + sum_max/2.
  - D is never 0 in DIV, guaranteed by the range check.
- Handshake: bpm_valid stays high until an edge with bpm_copied=1, and clears on that edge. bpm_copied while bpm_valid=0 has no effect. bpm_value holds its last value between results.
- clear_hist: synchronous; clears buffer, sum, fill and wr_ptr.
  - Asserted in LOAD/DIV/DONE: aborts to IDLE with no result, and bpm_valid is unchanged.
  - Same edge as an accept: clear wins and the interval is discarded, with no reject and no overrun pulse.
  - Does not clear a pending bpm_valid.
- en deasserted in LOAD/DIV/DONE: abort to IDLE with no result. History updates already made in LOAD are kept.
- Rounding: the result is the nearest integer of 60*FS*fill/sum. Ties round up.

Test Plan:
1. After reset, one interval 25 -> bpm_valid rises 18 cycles after acceptance, bpm_value=60 ((1500+12)/25). Pulse bpm_copied -> bpm_valid=0 on the next edge.
2. From empty history, intervals 25,25,20,20, each copied -> final bpm_value=67 ((6000+45)/90). interval_ready stays low throughout each computation.
3. Intervals 5, 0 and 51 -> each produces a bpm_reject pulse, no bpm_valid, and history unchanged. A following interval 25 still yields the case-2 continuation value.
4. After case 2, interval 30 (evicts the first 25) -> sum=95, bpm_value=63 ((6000+47)/95).
5. Leave bpm_valid uncopied and present interval 20 -> overrun pulse, interval_ready=0, history unchanged. Assert bpm_copied -> interval_ready=1 on the next cycle.
6. Assert rst_n low mid-DIV -> all outputs 0 immediately. Then apply clear_hist together with an interval -> interval discarded. Next, interval 20 -> bpm_value=75. Check the same abort paths with en=0 mid-DIV: no bpm_valid.
